obj_buf_ctrl: RTL

OBJ_BUF_CTRL -- requirements
Module: obj_buf_ctrl

---
 rtl/obj_buf_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/obj_buf_ctrl.sv
// obj_buf_ctrl: head/tail/occupancy control for the object field buffer.
// Arbitrates two push sources round-robin and serves one pop port.
module obj_buf_ctrl #(
  parameter int ROWS     = 64,
  parameter int AF_LEVEL = 56
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               wr_req,
  output logic [1:0]               wr_gnt,
  input  logic                     rd_req,
  output logic                     rd_ack,
  input  logic                     flush,
  output logic                     mem_we,
  output logic [$clog2(ROWS)-1:0]  mem_waddr,
  output logic                     mem_wsel,
  output logic                     mem_re,
  output logic [$clog2(ROWS)-1:0]  mem_raddr,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [$clog2(ROWS):0]    count
);

  localparam int AW = $clog2(ROWS);
  localparam logic [AW:0] ROWS_C = (AW+1)'(ROWS);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_LEVEL);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          rr;
  logic          push;
  logic          pop;
  logic [AW:0]   count_nxt;

  // Push arbitration: single requester wins outright, contention uses rr
  always_comb begin
    wr_gnt = 2'b00;
    if (!reset && !full && !flush) begin
      case (wr_req)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = rr ? 2'b10 : 2'b01;
        default: wr_gnt = 2'b00;
      endcase
    end
  end

  assign rd_ack    = rd_req & ~empty & ~flush & ~reset;
  assign push      = |wr_gnt;
  assign pop       = rd_ack;
  assign mem_we    = push;
  assign mem_wsel  = wr_gnt[1];
  assign mem_waddr = tail;
  assign mem_re    = pop;
  assign mem_raddr = head;

  // Next occupancy; flush discards everything
  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  // Pointer, occupancy, flag and priority registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rr          <= 1'b0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
      end
      if (wr_req == 2'b11 && push)
        rr <= ~rr;
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == ROWS_C);
      almost_full <= (count_nxt >= AF_C);
    end
  end

  a_count_bound: assert property (
    @(posedge clk) disable iff (reset) count <= ROWS_C);
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(count == ROWS_C && push && !pop));
  a_no_underflow: assert property (
    @(posedge clk) disable iff (reset) !(count == '0 && pop));

endmodule
